// File: rtl/clkmon_pkg.sv
// Shared types and helpers for the clock-monitor sweep sequencer.
// Holds the FSM state encoding, the count width and the per-channel status vector.
package clkmon_pkg;

    localparam int unsigned CNT_W   = 29;
    localparam int unsigned MAX_NCH = 8;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SEL    = 3'd1,
        ST_SETTLE = 3'd2,
        ST_GATE   = 3'd3,
        ST_WAIT   = 3'd4,
        ST_EVAL   = 3'd5
    } state_t;

    typedef logic [CNT_W-1:0]   count_t;
    typedef logic [MAX_NCH-1:0] chmask_t;

    // Counter width for a terminal count of p cycles (at least one bit).
    function automatic int unsigned cnt_w(input int unsigned p);
        return (p > 1) ? int'($clog2(p)) : 1;
    endfunction

    // Lowest set bit of a channel mask; 0 when the mask is empty.
    function automatic logic [2:0] first_ch(input chmask_t m);
        logic [2:0] r;
        r = 3'd0;
        for (int i = int'(MAX_NCH) - 1; i >= 0; i--) begin
            if (m[3'(i)]) r = 3'(i);
        end
        return r;
    endfunction

endpackage

// File: rtl/clkmon_nextch.sv
// Next-enabled-channel finder: lowest enabled channel above cur, or the
// lowest enabled channel overall with wrap set when cur is the last one.
module clkmon_nextch
    import clkmon_pkg::*;
#(
    parameter int unsigned NCH = 4,
    localparam int unsigned CHW = $clog2(NCH)
) (
    input  logic [CHW-1:0] cur,
    input  chmask_t        mask,
    output logic [CHW-1:0] nxt,
    output logic           wrap
);

    always_comb begin
        nxt  = CHW'(first_ch(mask));
        wrap = 1'b1;
        // Descending scan so the lowest qualifying channel wins.
        for (int unsigned i = MAX_NCH; i > 0; i--) begin
            if (mask[3'(i - 1)] && ((i - 1) > 32'(cur))) begin
                nxt  = CHW'(i - 1);
                wrap = 1'b0;
            end
        end
    end

endmodule

// File: rtl/clkmon_seq.sv
// Clock-monitor sweep sequencer: steps the clock mux over enabled channels,
// opens a fixed gate window, collects counts and grades them against limits.
module clkmon_seq
    import clkmon_pkg::*;
#(
    parameter int unsigned NCH      = 4,
    parameter int unsigned CLKCOUNT = 125000000,
    parameter int unsigned SETTLE   = 16,
    parameter int unsigned TMO      = 1024,
    localparam int unsigned CHW = $clog2(NCH)
) (
    input  logic             clkref,
    input  logic             rst,
    input  logic             start,
    input  logic             cont,
    input  logic [NCH-1:0]   chan_en,
    input  logic [CNT_W-1:0] lim_lo,
    input  logic [CNT_W-1:0] lim_hi,
    input  logic [CNT_W-1:0] meas_val,
    input  logic             meas_vld,
    output logic [CHW-1:0]   mon_sel,
    output logic             gate,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] res_val,
    output logic [CHW-1:0]   res_ch,
    output logic             res_stb,
    output logic [NCH-1:0]   ok,
    output logic [NCH-1:0]   bad,
    output logic [NCH-1:0]   tmo
);

    localparam int unsigned SW = cnt_w(SETTLE);
    localparam int unsigned GW = cnt_w(CLKCOUNT);
    localparam int unsigned TW = cnt_w(TMO);

    localparam logic [SW-1:0] S_LAST = SW'(SETTLE - 1);
    localparam logic [GW-1:0] G_LAST = GW'(CLKCOUNT - 1);
    localparam logic [TW-1:0] T_LAST = TW'(TMO - 1);

    state_t state_q, state_d;

    logic [NCH-1:0]   lmask_q, lmask_d;
    logic [SW-1:0]    settle_cnt_q, settle_cnt_d;
    logic [GW-1:0]    gate_cnt_q, gate_cnt_d;
    logic [TW-1:0]    tmo_cnt_q, tmo_cnt_d;
    logic             to_q, to_d;
    logic [CHW-1:0]   mon_sel_d, res_ch_d;
    logic [CNT_W-1:0] res_val_d;
    logic             gate_d, busy_d, done_d, res_stb_d;
    logic [NCH-1:0]   ok_d, bad_d, tmo_d;

    logic [CHW-1:0]   nxt_ch;
    logic             nxt_wrap;
    logic             accept_c;
    logic             in_win_c;
    chmask_t          lmask_ext;
    chmask_t          chan_en_ext;

    assign lmask_ext   = chmask_t'(lmask_q);
    assign chan_en_ext = chmask_t'(chan_en);
    assign accept_c    = start && (|chan_en);
    assign in_win_c    = (res_val >= lim_lo) && (res_val <= lim_hi);

    clkmon_nextch #(.NCH(NCH)) u_nextch (
        .cur  (mon_sel),
        .mask (lmask_ext),
        .nxt  (nxt_ch),
        .wrap (nxt_wrap)
    );

    always_ff @(posedge clkref or posedge rst) begin
        if (rst) state_q <= ST_IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE:   if (accept_c) state_d = ST_SEL;
            ST_SEL:    state_d = ST_SETTLE;
            ST_SETTLE: if (settle_cnt_q == S_LAST) state_d = ST_GATE;
            ST_GATE:   if (gate_cnt_q == G_LAST) state_d = ST_WAIT;
            ST_WAIT:   if (meas_vld || (tmo_cnt_q == T_LAST)) state_d = ST_EVAL;
            ST_EVAL:   state_d = (nxt_wrap && !cont) ? ST_IDLE : ST_SEL;
            default:   state_d = ST_IDLE;
        endcase
    end

    // Next values for every registered output and datapath register.
    always_comb begin
        lmask_d      = lmask_q;
        mon_sel_d    = mon_sel;
        res_val_d    = res_val;
        res_ch_d     = res_ch;
        ok_d         = ok;
        bad_d        = bad;
        tmo_d        = tmo;
        to_d         = to_q;
        settle_cnt_d = '0;
        gate_cnt_d   = '0;
        tmo_cnt_d    = '0;
        res_stb_d    = 1'b0;
        done_d       = 1'b0;
        gate_d       = (state_d == ST_GATE);
        busy_d       = (state_d != ST_IDLE);
        unique case (state_q)
            ST_IDLE: begin
                if (accept_c) begin
                    lmask_d   = chan_en;
                    mon_sel_d = CHW'(first_ch(chan_en_ext));
                    ok_d      = '0;
                    bad_d     = '0;
                    tmo_d     = '0;
                end
            end
            ST_SETTLE: begin
                if (state_d == ST_SETTLE) settle_cnt_d = settle_cnt_q + 1'b1;
            end
            ST_GATE: begin
                if (state_d == ST_GATE) gate_cnt_d = gate_cnt_q + 1'b1;
            end
            ST_WAIT: begin
                if (meas_vld) begin
                    res_val_d = meas_val;
                    res_ch_d  = mon_sel;
                    res_stb_d = 1'b1;
                    to_d      = 1'b0;
                end else if (tmo_cnt_q == T_LAST) begin
                    tmo_d[mon_sel] = 1'b1;
                    to_d           = 1'b1;
                end else begin
                    tmo_cnt_d = tmo_cnt_q + 1'b1;
                end
            end
            ST_EVAL: begin
                if (!to_q) begin
                    if (in_win_c) ok_d[mon_sel]  = 1'b1;
                    else          bad_d[mon_sel] = 1'b1;
                end
                mon_sel_d = nxt_ch;
                done_d    = nxt_wrap;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clkref or posedge rst) begin
        if (rst) begin
            lmask_q      <= '0;
            settle_cnt_q <= '0;
            gate_cnt_q   <= '0;
            tmo_cnt_q    <= '0;
            to_q         <= 1'b0;
            mon_sel      <= '0;
            gate         <= 1'b0;
            busy         <= 1'b0;
            done         <= 1'b0;
            res_val      <= '0;
            res_ch       <= '0;
            res_stb      <= 1'b0;
            ok           <= '0;
            bad          <= '0;
            tmo          <= '0;
        end else begin
            lmask_q      <= lmask_d;
            settle_cnt_q <= settle_cnt_d;
            gate_cnt_q   <= gate_cnt_d;
            tmo_cnt_q    <= tmo_cnt_d;
            to_q         <= to_d;
            mon_sel      <= mon_sel_d;
            gate         <= gate_d;
            busy         <= busy_d;
            done         <= done_d;
            res_val      <= res_val_d;
            res_ch       <= res_ch_d;
            res_stb      <= res_stb_d;
            ok           <= ok_d;
            bad          <= bad_d;
            tmo          <= tmo_d;
        end
    end

endmodule

// File: doc/clkmon_seq.md
CLKMON_SEQ -- requirements
Module: clkmon_seq

Interface
REQ-001 SHALL have parameter NCH, default 4, meaning number of monitored clock channels (2..8).
REQ-002 SHALL have parameter CLKCOUNT, default 125000000, meaning gate window length in clkref cycles.
REQ-003 SHALL have parameter SETTLE, default 16, meaning clkref cycles between mux select change and gate open.
REQ-004 SHALL have parameter TMO, default 1024, meaning clkref cycles allowed for meas_vld after gate close.
REQ-005 SHALL have port clkref  input  1  the single clock; one clock; reset is asynchronous and active-high.
REQ-006 SHALL have port rst  input  1  asynchronous active-high reset.
REQ-007 SHALL have port start  input  1  one-cycle pulse that begins a sweep.
REQ-008 SHALL have port cont  input  1  level; repeat sweeps while high.
REQ-009 SHALL have port chan_en  input  NCH  per-channel enable.
REQ-010 SHALL have port lim_lo / lim_hi  input  29 each  inclusive pass window for counts.
REQ-011 SHALL have port meas_val  input  29  count returned by the counter datapath.
REQ-012 SHALL have port meas_vld  input  1  one-cycle pulse; meas_val valid, already synchronized to clkref.
REQ-013 SHALL have port mon_sel  output  clog2(NCH)  clock mux select.
REQ-014 SHALL have port gate  output  1  measurement window to counter datapath.
REQ-015 SHALL have port busy / done  output  1 each  sweep active / one-cycle end-of-sweep pulse.
REQ-016 SHALL have port res_val, res_ch, res_stb  output  29, clog2(NCH), 1  last captured count, its channel, one-cycle strobe.
REQ-017 SHALL have port ok / bad / tmo  output  NCH each  sticky per-channel status.

Function
REQ-018 SHALL implement FSM IDLE -> SEL -> SETTLE -> GATE -> WAIT -> EVAL -> (SEL | IDLE).
REQ-019 IDLE: start with latched-candidate chan_en != 0 SHALL latch chan_en, clear ok/bad/tmo, go SEL at lowest enabled channel; start with chan_en == 0 SHALL be ignored.
REQ-020 start while busy SHALL be ignored; chan_en changes mid-sweep SHALL have no effect until next sweep.
REQ-021 SEL: mon_sel SHALL update in SEL and hold through EVAL; SETTLE SHALL last exactly SETTLE cycles.
REQ-022 GATE: gate SHALL be high for exactly CLKCOUNT consecutive cycles, then low on entry to WAIT.
REQ-023 WAIT: meas_vld SHALL capture meas_val into res_val, channel into res_ch, go EVAL; meas_vld in any other state SHALL be ignored.
REQ-024 WAIT with no meas_vld for TMO cycles SHALL set tmo[ch], leave res_val unchanged, go EVAL.
REQ-025 EVAL (one cycle): if not timed out, lim_lo <= res_val <= lim_hi SHALL set ok[ch], else bad[ch]; res_stb SHALL pulse in EVAL only when not timed out.
REQ-026 After EVAL, next channel SHALL be the next higher enabled latched channel; after the highest, done SHALL pulse and FSM SHALL go SEL at lowest enabled if cont high, else IDLE.
REQ-027 cont falling mid-sweep SHALL let the current sweep complete, then IDLE.
REQ-028 busy SHALL be high in every state except IDLE; lim_lo > lim_hi SHALL mark every non-timeout result bad.
REQ-029 Comparisons SHALL be unsigned 29-bit; gate/settle/timeout counters SHALL be sized by clog2 of their parameter and SHALL not wrap.

Reset
REQ-030 rst SHALL asynchronously force IDLE, gate=0, busy=0, done=0, res_stb=0, mon_sel=0, res_val=0, res_ch=0, ok/bad/tmo=0, latched enables=0.
REQ-031 rst asserted mid-GATE SHALL drop gate immediately, without waiting for a clkref edge.

Structure
REQ-032 Shared package clkmon_pkg SHALL hold the FSM state enum, the 29-bit count width constant and the status-vector typedef.
REQ-033 Channel selection SHALL be one sub-module clkmon_nextch: combinational next-enabled-channel finder from current channel and latched mask, with wrap flag.

Verification (NCH=4, CLKCOUNT=100, SETTLE=4, TMO=50)
REQ-034 chan_en=4'b0101, start, meas_vld 10 cycles after gate falls with 100 each, lim 90..110 -> mon_sel 0 then 2, gate high 100 cycles each, ok=0101, one done.
REQ-035 chan_en=4'b0010, meas_val=111, lim 90..110 -> bad=0010, res_val=111, res_stb once; meas_val=110 on rerun -> ok=0010.
REQ-036 chan_en=4'b1000, no meas_vld -> tmo=1000 exactly 50 cycles after gate falls, no res_stb, done.
REQ-037 cont=1, chan_en=4'b0011, cont dropped during channel 0 -> channel 1 completes, done, IDLE; start at chan_en=0 -> stays IDLE.
REQ-038 rst asserted 37 cycles into GATE -> gate low same cycle, all outputs at reset values; stray meas_vld in IDLE -> no state change.
